// File: rtl/image_rom_arbiter.sv
// Image ROM sharing: the display pixel path owns image slots, aux bursts use free slots.
// Returns a fixed-latency RGB stream and a registered aux read stream.
module image_rom_arbiter #(
  parameter int ROM_ADDR_BUS_WIDTH = 17,
  parameter int PIX_WIDTH          = 24,
  parameter int ROM_LATENCY        = 2,
  parameter int LEN_WIDTH          = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ROM_ADDR_BUS_WIDTH-1:0] disp_addr,
  input  logic                          disp_is_img,
  input  logic [PIX_WIDTH-1:0]          disp_pixel,
  input  logic                          disp_blank,
  output logic [ROM_ADDR_BUS_WIDTH-1:0] rom_addr,
  input  logic [PIX_WIDTH-1:0]          rom_q,
  output logic [PIX_WIDTH-1:0]          pix_out,
  output logic                          pix_blank,
  input  logic                          aux_req,
  input  logic [ROM_ADDR_BUS_WIDTH-1:0] aux_base,
  input  logic [LEN_WIDTH-1:0]          aux_len,
  output logic                          aux_busy,
  output logic                          aux_rvalid,
  output logic [PIX_WIDTH-1:0]          aux_rdata,
  output logic                          aux_done
);

  localparam int AW = ROM_ADDR_BUS_WIDTH;
  localparam int LW = LEN_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_t;

  typedef struct packed {
    logic                 disp;
    logic                 aux;
    logic                 last;
    logic [PIX_WIDTH-1:0] pixel;
    logic                 blank;
  } tag_t;

  state_t        state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic [LW-1:0] rem, rem_nx;
  logic          own_disp;
  logic          issue;
  logic          last;
  tag_t          tag_in;
  tag_t          tag_out;
  tag_t          pipe [ROM_LATENCY];

  assign own_disp = disp_is_img && !disp_blank;
  assign aux_busy = (state != IDLE);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    rem_nx   = rem;
    issue    = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (aux_req && aux_len != '0) begin
          state_nx = BURST;
          ptr_nx   = aux_base;
          rem_nx   = aux_len;
        end
      end
      BURST: begin
        if (!own_disp) begin
          issue  = 1'b1;
          last   = (rem == LW'(1));
          ptr_nx = ptr + AW'(1);
          rem_nx = rem - LW'(1);
          if (last) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        // aux_done is registered, so a request seen alongside it is dropped
        if (aux_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      rem   <= rem_nx;
    end
  end

  assign rom_addr = own_disp ? disp_addr :
                    (issue ? ptr : '0);

  assign tag_in  = {own_disp, issue, last,
                    disp_pixel, disp_blank};
  assign tag_out = pipe[ROM_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LATENCY; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < ROM_LATENCY; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out    <= '0;
      pix_blank  <= 1'b0;
      aux_rvalid <= 1'b0;
      aux_rdata  <= '0;
      aux_done   <= 1'b0;
    end else begin
      pix_out    <= tag_out.disp ? rom_q : tag_out.pixel;
      pix_blank  <= tag_out.blank;
      aux_rvalid <= tag_out.aux;
      aux_done   <= tag_out.aux && tag_out.last;
      if (tag_out.aux) aux_rdata <= rom_q;
    end
  end

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Directed bench for image_rom_arbiter with a 2-cycle ROM model (q = addr).
// Pixel stream checked against a 3-cycle golden queue, aux words against expected lists.
module tb_image_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic [16:0] disp_addr;
  logic        disp_is_img;
  logic [23:0] disp_pixel;
  logic        disp_blank;
  logic [16:0] rom_addr;
  logic [23:0] rom_q;
  logic [23:0] pix_out;
  logic        pix_blank;
  logic        aux_req;
  logic [16:0] aux_base;
  logic [7:0]  aux_len;
  logic        aux_busy;
  logic        aux_rvalid;
  logic [23:0] aux_rdata;
  logic        aux_done;

  int total;
  int bad;

  logic [23:0] pq[$];
  logic        bq[$];
  logic [16:0] aux_q[$];
  logic [16:0] r1, r2;

  image_rom_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp_addr   (disp_addr),
    .disp_is_img (disp_is_img),
    .disp_pixel  (disp_pixel),
    .disp_blank  (disp_blank),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .pix_out     (pix_out),
    .pix_blank   (pix_blank),
    .aux_req     (aux_req),
    .aux_base    (aux_base),
    .aux_len     (aux_len),
    .aux_busy    (aux_busy),
    .aux_rvalid  (aux_rvalid),
    .aux_rdata   (aux_rdata),
    .aux_done    (aux_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    r1 <= rom_addr;
    r2 <= r1;
  end
  assign rom_q = {7'b0, r2};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic        img,
                     input logic        blank,
                     input logic [16:0] a,
                     input logic [23:0] px,
                     input logic        req,
                     input logic [16:0] base,
                     input logic [7:0]  len,
                     input logic [16:0] e_rom,
                     input logic        e_busy,
                     input logic        e_rv,
                     input logic        e_done);
    logic [23:0] ed;
    @(posedge clk);
    #1;
    disp_is_img = img;
    disp_blank  = blank;
    disp_addr   = a;
    disp_pixel  = px;
    aux_req     = req;
    aux_base    = base;
    aux_len     = len;
    #1;
    chk("rom_addr", 32'(rom_addr), 32'(e_rom));
    chk("aux_busy", 32'(aux_busy), 32'(e_busy));
    chk("aux_rvalid", 32'(aux_rvalid), 32'(e_rv));
    chk("aux_done", 32'(aux_done), 32'(e_done));
    if (aux_rvalid) begin
      ed = 24'hBADBAD;
      if (aux_q.size() != 0) ed = {7'b0, aux_q.pop_front()};
      chk("aux_rdata", 32'(aux_rdata), 32'(ed));
    end
    pq.push_back((img && !blank) ? {7'b0, a} : px);
    bq.push_back(blank);
    if (pq.size() > 3) begin
      chk("pix_out", 32'(pix_out), 32'(pq.pop_front()));
      chk("pix_blank", 32'(pix_blank), 32'(bq.pop_front()));
    end
  endtask

  task automatic idle(input int n);
    repeat (n)
      cyc(1'b0, 1'b1, 17'h0, 24'h0000AA, 1'b0, 17'h0, 8'd0,
          17'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'h0);
    chk({tag, "_pix_out"}, 32'(pix_out), 32'h0);
    chk({tag, "_pix_blank"}, 32'(pix_blank), 32'h0);
    chk({tag, "_aux_busy"}, 32'(aux_busy), 32'h0);
    chk({tag, "_aux_rvalid"}, 32'(aux_rvalid), 32'h0);
    chk({tag, "_aux_rdata"}, 32'(aux_rdata), 32'h0);
    chk({tag, "_aux_done"}, 32'(aux_done), 32'h0);
  endtask

  initial begin
    logic        im;
    logic [16:0] er;
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    disp_addr   = '0;
    disp_is_img = 1'b0;
    disp_pixel  = '0;
    disp_blank  = 1'b0;
    aux_req     = 1'b0;
    aux_base    = '0;
    aux_len     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // display only: image pixels, then fallback colour, one blank pixel
    for (int c = 0; c < 12; c++) begin
      im = (c < 5);
      cyc(im, c == 7, 17'h100 + 17'(c),
          im ? 24'h123456 : 24'hFFFFFF,
          1'b0, 17'h0, 8'd0,
          im ? 17'h100 + 17'(c) : 17'h0,
          1'b0, 1'b0, 1'b0);
    end

    // burst of 4 during blanking
    for (int k = 0; k < 4; k++)
      aux_q.push_back(17'h1D4C0 + 17'(k));
    cyc(1'b0, 1'b1, 17'h0, 24'h000011, 1'b1, 17'h1D4C0, 8'd4,
        17'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      cyc(1'b0, 1'b1, 17'h0, 24'h000012, 1'b0, 17'h0, 8'd0,
          17'h1D4C0 + 17'(k), 1'b1, k == 3, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000013, 1'b0, 17'h0, 8'd0,
        17'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000014, 1'b0, 17'h0, 8'd0,
        17'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000015, 1'b0, 17'h0, 8'd0,
        17'h0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 17'h0, 24'h000016, 1'b0, 17'h0, 8'd0,
        17'h0, 1'b0, 1'b0, 1'b0);
    chk("burst4_left", 32'(aux_q.size()), 32'h0);

    // interleave with image pixels on even cycles
    for (int k = 0; k < 3; k++)
      aux_q.push_back(17'h00A00 + 17'(k));
    for (int c = 0; c < 11; c++) begin
      im = (c % 2 == 0);
      er = im ? 17'h200 + 17'(c) :
           (c == 1) ? 17'h00A00 :
           (c == 3) ? 17'h00A01 :
           (c == 5) ? 17'h00A02 : 17'h0;
      cyc(im, 1'b0, 17'h200 + 17'(c),
          24'hA00000 + 24'(c),
          c == 0, 17'h00A00, 8'd3, er,
          c >= 1 && c <= 8,
          c == 4 || c == 6 || c == 8,
          c == 8);
    end
    chk("inter_left", 32'(aux_q.size()), 32'h0);

    // wrap, with aux_req held high across the whole burst
    aux_q.push_back(17'h1FFFF);
    aux_q.push_back(17'h00000);
    cyc(1'b0, 1'b1, 17'h0, 24'h000021, 1'b1, 17'h1FFFF, 8'd2,
        17'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000022, 1'b1, 17'h12345, 8'd5,
        17'h1FFFF, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000023, 1'b1, 17'h12345, 8'd5,
        17'h00000, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000024, 1'b1, 17'h12345, 8'd5,
        17'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000025, 1'b1, 17'h12345, 8'd5,
        17'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000026, 1'b1, 17'h12345, 8'd5,
        17'h0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 17'h0, 24'h000027, 1'b0, 17'h0, 8'd0,
        17'h0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("wrap_left", 32'(aux_q.size()), 32'h0);

    // zero-length request is ignored
    repeat (3)
      cyc(1'b0, 1'b1, 17'h0, 24'h000031, 1'b1, 17'h0ABCD, 8'd0,
          17'h0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // reset with two words in flight
    cyc(1'b0, 1'b1, 17'h0, 24'h000041, 1'b1, 17'h00300, 8'd6,
        17'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000042, 1'b0, 17'h0, 8'd0,
        17'h00300, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000043, 1'b0, 17'h0, 8'd0,
        17'h00301, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    disp_is_img = 1'b0;
    disp_blank  = 1'b1;
    aux_req     = 1'b0;
    #1;
    chk_zero("midrst");
    pq.delete();
    bq.delete();
    aux_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);

    aux_q.push_back(17'h00400);
    aux_q.push_back(17'h00401);
    cyc(1'b0, 1'b1, 17'h0, 24'h000051, 1'b1, 17'h00400, 8'd2,
        17'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000052, 1'b0, 17'h0, 8'd0,
        17'h00400, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000053, 1'b0, 17'h0, 8'd0,
        17'h00401, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000054, 1'b0, 17'h0, 8'd0,
        17'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000055, 1'b0, 17'h0, 8'd0,
        17'h0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 17'h0, 24'h000056, 1'b0, 17'h0, 8'd0,
        17'h0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 17'h0, 24'h000057, 1'b0, 17'h0, 8'd0,
        17'h0, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("post_rst_left", 32'(aux_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
